// File: rtl/booth_divider.sv
// Sequential restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor, one quotient bit per clock.
// Macro DIV_SIGNED_EN selects two's-complement operands; without it, operands are unsigned.
//
// state  | meaning
// S_IDLE | waiting for Start; results and flags from the last operation stay visible
// S_ITER | shift/subtract, one quotient bit per edge, MSB first
// S_FIX  | sign correction and signed range check, then results are committed
// S_DONE | results valid; leave when Start drops
module booth_divider #(
    parameter int WIDTH = 8
) (
    input  logic                 i_clock,
    input  logic                 i_resetn,
    input  logic                 i_start,
    input  logic [2*WIDTH-1:0]   i_dividend,
    input  logic [WIDTH-1:0]     i_divisor,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [WIDTH-1:0]     o_quotient,
    output logic [WIDTH-1:0]     o_remainder,
    output logic                 o_div_zero,
    output logic                 o_overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [CW-1:0]        r_cnt;
    logic [WIDTH-1:0]     r_rem;
    logic [WIDTH-1:0]     r_quo;
    logic [WIDTH-1:0]     r_dvsr;
    logic [WIDTH-1:0]     r_q_res;
    logic [WIDTH-1:0]     r_r_res;
    logic                 r_dz;
    logic                 r_ov;

    logic [2*WIDTH-1:0]   w_dvd_mag;
    logic [WIDTH-1:0]     w_dvsr_mag;
    logic                 w_dvsr_zero;
    logic                 w_early_ov;
    logic [WIDTH:0]       w_rem_sh;
    logic [WIDTH:0]       w_trial;
    logic                 w_trial_neg;

`ifdef DIV_SIGNED_EN
    localparam logic [WIDTH-1:0] Q_POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] Q_NEG_MAX = {1'b1, {(WIDTH-1){1'b0}}};

    logic                 r_neg_q;
    logic                 r_neg_r;
    logic [WIDTH-1:0]     w_q_fix;
    logic [WIDTH-1:0]     w_r_fix;
    logic                 w_range_ov;

    assign w_dvd_mag  = i_dividend[2*WIDTH-1] ? -i_dividend : i_dividend;
    assign w_dvsr_mag = i_divisor[WIDTH-1]    ? -i_divisor  : i_divisor;
    assign w_q_fix    = r_neg_q ? -r_quo : r_quo;
    assign w_r_fix    = r_neg_r ? -r_rem : r_rem;
    assign w_range_ov = r_neg_q ? (r_quo > Q_NEG_MAX) : (r_quo > Q_POS_MAX);
`else
    assign w_dvd_mag  = i_dividend;
    assign w_dvsr_mag = i_divisor;
`endif

    // Upper half >= divisor means the quotient cannot fit in WIDTH bits at all.
    assign w_dvsr_zero = (i_divisor == '0);
    assign w_early_ov  = (w_dvd_mag[2*WIDTH-1:WIDTH] >= w_dvsr_mag);

    // rem < divisor holds before each step, so the trial lies in [-divisor, divisor-1]
    // and WIDTH+1 bits carry it exactly.
    assign w_rem_sh    = {r_rem, r_quo[WIDTH-1]};
    assign w_trial     = w_rem_sh - {1'b0, r_dvsr};
    assign w_trial_neg = w_trial[WIDTH];

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next = (w_dvsr_zero || w_early_ov) ? S_DONE : S_ITER;
                end
            end
            S_ITER: begin
                if (r_cnt == '0) begin
                    w_next = S_FIX;
                end
            end
            S_FIX: begin
                w_next = S_DONE;
            end
            S_DONE: begin
                if (!i_start) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvsr  <= '0;
            r_q_res <= '0;
            r_r_res <= '0;
            r_dz    <= 1'b0;
            r_ov    <= 1'b0;
`ifdef DIV_SIGNED_EN
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_dvsr <= w_dvsr_mag;
                        r_rem  <= w_dvd_mag[2*WIDTH-1:WIDTH];
                        r_quo  <= w_dvd_mag[WIDTH-1:0];
                        r_cnt  <= CNT_INIT;
                        r_dz   <= w_dvsr_zero;
                        r_ov   <= !w_dvsr_zero && w_early_ov;
`ifdef DIV_SIGNED_EN
                        r_neg_q <= i_dividend[2*WIDTH-1] ^ i_divisor[WIDTH-1];
                        r_neg_r <= i_dividend[2*WIDTH-1];
`endif
                        if (w_dvsr_zero || w_early_ov) begin
                            r_q_res <= '0;
                            r_r_res <= '0;
                        end
                    end
                end
                S_ITER: begin
                    r_rem <= w_trial_neg ? w_rem_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];
                    r_quo <= {r_quo[WIDTH-2:0], ~w_trial_neg};
                    r_cnt <= r_cnt - CW'(1);
                end
                S_FIX: begin
`ifdef DIV_SIGNED_EN
                    if (w_range_ov) begin
                        r_ov    <= 1'b1;
                        r_q_res <= '0;
                        r_r_res <= '0;
                    end else begin
                        r_q_res <= w_q_fix;
                        r_r_res <= w_r_fix;
                    end
`else
                    r_q_res <= r_quo;
                    r_r_res <= r_rem;
`endif
                end
                default: begin
                end
            endcase
        end
    end

    // Output stage: everything visible lags the internal state by one edge.
    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_quotient  <= '0;
            o_remainder <= '0;
            o_div_zero  <= 1'b0;
            o_overflow  <= 1'b0;
        end else begin
            o_busy      <= (r_state == S_ITER) || (r_state == S_FIX);
            o_done      <= (r_state == S_DONE);
            o_quotient  <= r_q_res;
            o_remainder <= r_r_res;
            o_div_zero  <= r_dz;
            o_overflow  <= r_ov;
        end
    end

endmodule

// File: tb/tb_booth_divider.sv
// Self-checking bench for booth_divider (WIDTH=8): integer-arithmetic reference model,
// per-cycle output compare while Done is high, directed corner cases and random operations.
module tb_booth_divider;

    localparam int W = 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic [15:0]   dvd;
    logic [7:0]    dvs;
    logic          o_busy;
    logic          o_done;
    logic [7:0]    o_quotient;
    logic [7:0]    o_remainder;
    logic          o_div_zero;
    logic          o_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q;
    logic [7:0] exp_r;
    logic       exp_dz;
    logic       exp_ov;
    int         exp_lat;

    booth_divider #(.WIDTH(W)) dut (
        .i_clock     (clk),
        .i_resetn    (rstn),
        .i_start     (start),
        .i_dividend  (dvd),
        .i_divisor   (dvs),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_quotient  (o_quotient),
        .o_remainder (o_remainder),
        .o_div_zero  (o_div_zero),
        .o_overflow  (o_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // Reference: plain integer division (truncating, remainder follows dividend sign).
    function automatic void model(input logic [15:0] a, input logic [7:0] b,
                                  output logic [7:0] q, output logic [7:0] r,
                                  output logic dz, output logic ov, output int lat);
        int ai, bi, qi, ri;
`ifdef DIV_SIGNED_EN
        ai = $signed(a);
        bi = $signed(b);
`else
        ai = int'(a);
        bi = int'(b);
`endif
        q = 8'h00; r = 8'h00; dz = 1'b0; ov = 1'b0; lat = W + 2;
        if (bi == 0) begin
            dz = 1'b1;
            lat = 1;
        end else begin
            qi = ai / bi;
            ri = ai % bi;
            if (qi >= (1 << W) || qi <= -(1 << W)) begin
                ov = 1'b1;
                lat = 1;
`ifdef DIV_SIGNED_EN
            end else if (qi > 127 || qi < -128) begin
                ov = 1'b1;
`endif
            end else begin
                q = qi[7:0];
                r = ri[7:0];
            end
        end
    endfunction

    // Whenever Done is high the visible results must match the current expectation.
    always begin
        @(posedge clk);
        #1;
        if (rstn === 1'b1 && o_done === 1'b1) begin
            chk("done_quotient",  o_quotient,  exp_q);
            chk("done_remainder", o_remainder, exp_r);
            chk("done_divzero",   o_div_zero,  exp_dz);
            chk("done_overflow",  o_overflow,  exp_ov);
            chk("done_busy_low",  o_busy,      1'b0);
        end
    end

    task automatic run_op(input logic [15:0] a, input logic [7:0] b, input int hold);
        int  n;
        bit  seen;
        n = 0;
        while ((o_done !== 1'b0 || o_busy !== 1'b0) && n < 40) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 40) timeout("wait_idle");
        model(a, b, exp_q, exp_r, exp_dz, exp_ov, exp_lat);
        @(negedge clk);
        dvd = a; dvs = b; start = 1'b1;
        @(posedge clk); #1;
        dvd = 16'($urandom); dvs = 8'($urandom);
        n = 0; seen = 0;
        while (!seen && n < 30) begin
            @(posedge clk); #1; n++;
            if (o_done === 1'b1) seen = 1;
            else begin
                dvd = 16'($urandom); dvs = 8'($urandom);
            end
        end
        chk("latency", n, exp_lat);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_done", o_done, 1'b1);
            chk("no_rerun",  o_busy, 1'b0);
        end
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (o_done !== 1'b0 && n < 5) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 5) timeout("done_fall");
        chk("kept_quotient",  o_quotient,  exp_q);
        chk("kept_remainder", o_remainder, exp_r);
        chk("kept_divzero",   o_div_zero,  exp_dz);
        chk("kept_overflow",  o_overflow,  exp_ov);
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_busy"},      o_busy,      1'b0);
        chk({tag, "_done"},      o_done,      1'b0);
        chk({tag, "_quotient"},  o_quotient,  8'h00);
        chk({tag, "_remainder"}, o_remainder, 8'h00);
        chk({tag, "_divzero"},   o_div_zero,  1'b0);
        chk({tag, "_overflow"},  o_overflow,  1'b0);
    endtask

    initial begin
        logic [7:0]  pq, pr, b;
        logic        pdz, pov;
        int          plat;
        logic [15:0] a;
        logic [7:0]  x;

        rstn = 1'b0; start = 1'b0; dvd = '0; dvs = '0;
        exp_q = '0; exp_r = '0; exp_dz = 1'b0; exp_ov = 1'b0; exp_lat = 0;
        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset");
        @(negedge clk);
        rstn = 1'b1;

        // Pin the model to hand-computed values.
        model(16'h0064, 8'h07, pq, pr, pdz, pov, plat);
        chk("pin_100_7_q", pq, 8'h0E);
        chk("pin_100_7_r", pr, 8'h02);
        chk("pin_100_7_lat", plat, 10);
        model(16'h1234, 8'h00, pq, pr, pdz, pov, plat);
        chk("pin_dz_flag", pdz, 1'b1);
        chk("pin_dz_lat", plat, 1);
        model(16'h4000, 8'h02, pq, pr, pdz, pov, plat);
        chk("pin_ov_flag", pov, 1'b1);
        chk("pin_ov_q", pq, 8'h00);
`ifdef DIV_SIGNED_EN
        model(16'hFF9C, 8'h07, pq, pr, pdz, pov, plat);
        chk("pin_neg100_7_q", pq, 8'hF2);
        chk("pin_neg100_7_r", pr, 8'hFE);
        model(16'hFF00, 8'h02, pq, pr, pdz, pov, plat);
        chk("pin_neg256_2_q", pq, 8'h80);
        chk("pin_neg256_2_ov", pov, 1'b0);
`else
        model(16'hFF9C, 8'h07, pq, pr, pdz, pov, plat);
        chk("pin_u_ff9c_ov", pov, 1'b1);
        chk("pin_u_ff9c_lat", plat, 1);
`endif

        run_op(16'h0064, 8'h07, 20);
        run_op(16'hFF9C, 8'h07, 2);
        run_op(16'hFF00, 8'h02, 1);
        run_op(16'h1234, 8'h00, 2);
        run_op(16'h4000, 8'h02, 1);
        run_op(16'h0080, 8'h01, 1);
        run_op(16'h0080, 8'hFF, 1);
        run_op(16'h8000, 8'h80, 1);
        run_op(16'h00FF, 8'hFF, 1);
        run_op(16'h0000, 8'h05, 1);

        // Abort in the middle of the iterations.
        @(negedge clk);
        dvd = 16'h0064; dvs = 8'h07; start = 1'b1;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        check_cleared("abort");
        start = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_cleared("after_abort");
        run_op(16'h0064, 8'h07, 1);

        for (int k = 0; k < 200; k++) begin
            case ($urandom_range(0, 3))
                0: begin
                    a = 16'($urandom);
                    b = 8'($urandom);
                end
                1: begin
                    b = 8'($urandom_range(1, 255));
                    a = 16'(($urandom_range(0, int'(b) - 1) << 8) | $urandom_range(0, 255));
                end
                2: begin
                    x = 8'($urandom);
                    a = {{8{x[7]}}, x};
                    b = 8'($urandom);
                end
                default: begin
                    a = 16'($urandom);
                    b = 8'($urandom_range(0, 3));
                end
            endcase
            run_op(a, b, $urandom_range(1, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
